// File: rtl/pv2ooo_inst_queue_pkg.sv
// Shared PARC instruction-message layout, format classes and opcodes for the
// pv2ooo instruction queue and any decode logic that splits raw instructions.
package pv2ooo_inst_queue_pkg;

    localparam int PARC_INST_MSG_SZ         = 32;
    localparam int PARC_INST_MSG_OPCODE_MSB = 31;
    localparam int PARC_INST_MSG_OPCODE_LSB = 26;
    localparam int PARC_INST_MSG_RS_MSB     = 25;
    localparam int PARC_INST_MSG_RS_LSB     = 21;
    localparam int PARC_INST_MSG_RT_MSB     = 20;
    localparam int PARC_INST_MSG_RT_LSB     = 16;
    localparam int PARC_INST_MSG_RD_MSB     = 15;
    localparam int PARC_INST_MSG_RD_LSB     = 11;
    localparam int PARC_INST_MSG_SHAMT_MSB  = 10;
    localparam int PARC_INST_MSG_SHAMT_LSB  = 6;
    localparam int PARC_INST_MSG_FUNC_MSB   = 5;
    localparam int PARC_INST_MSG_FUNC_LSB   = 0;
    localparam int PARC_INST_MSG_IMM_MSB    = 15;
    localparam int PARC_INST_MSG_IMM_LSB    = 0;
    localparam int PARC_INST_MSG_TARGET_MSB = 25;
    localparam int PARC_INST_MSG_TARGET_LSB = 0;

    localparam logic [5:0] PARC_OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] PARC_OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] PARC_OPC_J        = 6'b000010;
    localparam logic [5:0] PARC_OPC_JAL      = 6'b000011;

    typedef enum logic [1:0] {
        PARC_INST_FMT_RR   = 2'd0,
        PARC_INST_FMT_RI   = 2'd1,
        PARC_INST_FMT_TARG = 2'd2
    } parc_inst_fmt_e;

    function automatic parc_inst_fmt_e parcInstFmt(input logic [5:0] opcode);
        case (opcode)
            PARC_OPC_SPECIAL, PARC_OPC_SPECIAL2: parcInstFmt = PARC_INST_FMT_RR;
            PARC_OPC_J, PARC_OPC_JAL:            parcInstFmt = PARC_INST_FMT_TARG;
            default:                             parcInstFmt = PARC_INST_FMT_RI;
        endcase
    endfunction

endpackage

// File: rtl/pv2ooo_inst_fields.sv
// Combinational PARC field splitter and format classifier; reusable by decode.
module pv2ooo_inst_fields
    import pv2ooo_inst_queue_pkg::*;
(
    input  logic [PARC_INST_MSG_SZ-1:0] i_inst,
    output logic [5:0]                  o_opcode,
    output logic [4:0]                  o_rs,
    output logic [4:0]                  o_rt,
    output logic [4:0]                  o_rd,
    output logic [4:0]                  o_shamt,
    output logic [5:0]                  o_func,
    output logic [31:0]                 o_imm_sext,
    output logic [25:0]                 o_target,
    output logic [1:0]                  o_fmt
);

    assign o_opcode   = i_inst[PARC_INST_MSG_OPCODE_MSB:PARC_INST_MSG_OPCODE_LSB];
    assign o_rs       = i_inst[PARC_INST_MSG_RS_MSB:PARC_INST_MSG_RS_LSB];
    assign o_rt       = i_inst[PARC_INST_MSG_RT_MSB:PARC_INST_MSG_RT_LSB];
    assign o_rd       = i_inst[PARC_INST_MSG_RD_MSB:PARC_INST_MSG_RD_LSB];
    assign o_shamt    = i_inst[PARC_INST_MSG_SHAMT_MSB:PARC_INST_MSG_SHAMT_LSB];
    assign o_func     = i_inst[PARC_INST_MSG_FUNC_MSB:PARC_INST_MSG_FUNC_LSB];
    assign o_imm_sext = {{16{i_inst[PARC_INST_MSG_IMM_MSB]}},
                         i_inst[PARC_INST_MSG_IMM_MSB:PARC_INST_MSG_IMM_LSB]};
    assign o_target   = i_inst[PARC_INST_MSG_TARGET_MSB:PARC_INST_MSG_TARGET_LSB];
    assign o_fmt      = parcInstFmt(o_opcode);

endmodule

// File: rtl/pv2ooo_inst_queue.sv
// Fetch-to-decode instruction buffer: circular {pc, inst} queue with val/rdy
// handshakes, occupancy count, squash flush and a pre-split head instruction.
module pv2ooo_inst_queue
    import pv2ooo_inst_queue_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int PC_SZ       = 32,
    parameter int CNT_SZ      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_val,
    output logic              enq_rdy,
    input  logic [PC_SZ-1:0]  enq_pc,
    input  logic [31:0]       enq_inst,
    output logic              deq_val,
    input  logic              deq_rdy,
    output logic [PC_SZ-1:0]  deq_pc,
    output logic [31:0]       deq_inst,
    output logic [5:0]        deq_opcode,
    output logic [4:0]        deq_rs,
    output logic [4:0]        deq_rt,
    output logic [4:0]        deq_rd,
    output logic [4:0]        deq_shamt,
    output logic [5:0]        deq_func,
    output logic [31:0]       deq_imm_sext,
    output logic [25:0]       deq_target,
    output logic [1:0]        deq_fmt,
    output logic [CNT_SZ-1:0] count
);

    localparam int PTR_SZ = $clog2(NUM_ENTRIES);

    logic [PC_SZ-1:0]  r_pc   [NUM_ENTRIES];
    logic [31:0]       r_inst [NUM_ENTRIES];
    logic [PTR_SZ-1:0] r_head;
    logic [PTR_SZ-1:0] r_tail;
    logic [CNT_SZ-1:0] r_count;
    logic              w_enq_fire;
    logic              w_deq_fire;

    assign enq_rdy    = (r_count != CNT_SZ'(NUM_ENTRIES)) && !flush;
    assign deq_val    = (r_count != '0);
    assign w_enq_fire = enq_val && enq_rdy;
    assign w_deq_fire = deq_val && deq_rdy;
    assign count      = r_count;
    assign deq_pc     = r_pc[r_head];
    assign deq_inst   = r_inst[r_head];

    // Storage is cleared on reset so the head fields never show X; flush only
    // rewinds the pointers since stale entries are hidden behind deq_val.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) begin
                r_pc[r_tail]   <= enq_pc;
                r_inst[r_tail] <= enq_inst;
                r_tail         <= r_tail + PTR_SZ'(1);
            end
            if (w_deq_fire) begin
                r_head <= r_head + PTR_SZ'(1);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CNT_SZ'(1);
                2'b01:   r_count <= r_count - CNT_SZ'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    pv2ooo_inst_fields u_fields (
        .i_inst     (deq_inst),
        .o_opcode   (deq_opcode),
        .o_rs       (deq_rs),
        .o_rt       (deq_rt),
        .o_rd       (deq_rd),
        .o_shamt    (deq_shamt),
        .o_func     (deq_func),
        .o_imm_sext (deq_imm_sext),
        .o_target   (deq_target),
        .o_fmt      (deq_fmt)
    );

endmodule

// File: doc/pv2ooo_inst_queue.md
Name: pv2ooo_inst_queue

Overview:
- Parametrised instruction buffer between fetch and decode/rename in the pv2ooo out-of-order core.
- Holds up to NUM_ENTRIES {pc, inst} pairs, with val/rdy handshakes on both sides and a flush for mispredict squash.
- Presents the head instruction pre-split into PARC message fields (opcode/rs/rt/rd/shamt/func/imm/target) plus a format class.
- Successor to the combinational instruction-message field layout: generalised depth and PC width, with buffering, occupancy tracking and squash.

Parameters:
- NUM_ENTRIES, 4, queue depth; power of two, >= 2.
- PC_SZ, 32, width of the stored PC.
- CNT_SZ, $clog2(NUM_ENTRIES+1), width of the occupancy count.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  squash all entries this cycle.
- enq_val  in  1  fetch offers an instruction.
- enq_rdy  out  1  queue accepts.
- enq_pc  in  PC_SZ  PC of the offered instruction.
- enq_inst  in  32  raw PARC instruction.
- deq_val  out  1  head entry valid.
- deq_rdy  in  1  decode consumes the head.
- deq_pc  out  PC_SZ  head PC.
- deq_inst  out  32  head raw instruction.
- deq_opcode, deq_rs, deq_rt, deq_rd, deq_shamt, deq_func  out  6/5/5/5/5/6  head fields at the standard PARC bit positions [31:26], [25:21], [20:16], [15:11], [10:6], [5:0].
- deq_imm_sext  out  32  inst[15:0] sign-extended.
- deq_target  out  26  inst[25:0].
- deq_fmt  out  2  format class: 0 = reg-reg, 1 = reg-imm, 2 = target.
- count  out  CNT_SZ  current occupancy.

Behaviour:
- Storage and pointers:
  - Circular array with head/tail pointers of log2(NUM_ENTRIES) bits; pointers wrap modulo NUM_ENTRIES.
  - Occupancy is held in a separate count register.
- Reset (asynchronous): head = tail = count = 0. Outputs during and after reset: deq_val = 0, enq_rdy = 1. Storage contents are don't-care.
- Handshake rules:
  - enq fire = enq_val & enq_rdy.
  - deq fire = deq_val & deq_rdy.
  - enq_rdy = (count != NUM_ENTRIES) & !flush. It is combinational and does not depend on deq_rdy, so a full queue will not accept even while dequeuing.
  - deq_val = (count != 0).
  - All deq_* data outputs read the head entry combinationally.
- Latency: an instruction enqueued at edge N is visible on deq_val after edge N. There is no same-cycle bypass, so minimum enq-to-deq is 1 cycle.
- Simultaneous enq and deq fire with 0 < count < NUM_ENTRIES: count is unchanged and both pointers advance.
- Full queue with deq fire: count becomes NUM_ENTRIES-1 and enq_rdy rises the next cycle.
- Empty queue: deq_val = 0. deq_rdy is ignored and the pointers do not move.
- Flush has priority over everything:
  - On an edge with flush = 1: head = tail = count = 0.
  - Any concurrent enq is dropped (enq_rdy is already 0).
  - A concurrent deq fire is still considered taken by the consumer, but the entry is discarded by the flush.
  - The queue is usable the cycle after flush.
- Format classification (combinational on the head):
  - opcode 6'b000000 or 6'b011100 -> 0 (reg-reg).
  - opcode 6'b000010 or 6'b000011 -> 2 (target).
  - all other opcodes -> 1 (reg-imm).
- Field outputs are valid only while deq_val = 1; otherwise they are don't-care but must not be X after reset. Storage therefore initialises to 0 on reset, or the outputs are masked.
- Reset mid-operation: all entries are lost at once and the queue behaves as freshly reset. No partial dequeue may be observed.

Decomposition:
- Shared package/header additions (alongside the existing PARC instruction-message defines):
  - field ranges/sizes reused from the existing `PARC_INST_MSG_*` defines;
  - new `PARC_INST_FMT_RR` / `PARC_INST_FMT_RI` / `PARC_INST_FMT_TARG` constants;
  - opcode constants for SPECIAL2 (MUL) and J/JAL.
- One natural sub-module: pv2ooo_inst_fields, the combinational field splitter and format classifier driven by deq_inst. It is reusable by the decode stage.

Test Plan:
- Reset, then enq ADDU {0,2,3,4,0,0x21} at pc 0x1000 -> next cycle deq_val = 1, deq_pc = 0x1000, deq_rs = 2, deq_rt = 3, deq_rd = 4, deq_func = 0x21, deq_fmt = 0, count = 1.
- Enq LH {0x21,30,12,0xffff} -> deq_imm_sext = 0xffffffff, deq_fmt = 1. Enq JAL target 0x3fffff0 -> deq_target = 0x3fffff0, deq_fmt = 2.
- Fill with 4 entries, deq_rdy = 0 -> count = 4 and enq_rdy = 0. Assert deq_rdy for one cycle with enq_val held -> count 3; the enq is accepted on the following cycle; FIFO order is preserved across pointer wrap over 10 total entries.
- Steady state with enq and deq firing every cycle for 8 cycles -> count constant at 1 and in-order PCs 0x0, 0x4, …, 0x1c.
- With 3 entries, assert flush together with enq_val = 1 -> enq_rdy = 0 that cycle; next cycle count = 0 and deq_val = 0; a subsequent enq appears one cycle later.
- Assert reset asynchronously between edges with 2 entries held -> deq_val falls immediately with no clock edge needed, and count = 0.
